// File: rtl/fill_scheduler_if.sv
// Job, fill-unit and completion signals between the triangle setup stage,
// the scanline fill unit, the frame controller and fill_scheduler.
interface fill_scheduler_if #(
  parameter int ID_W = 4
);
  logic            abort;
  logic            job_valid;
  logic            job_ready;
  logic [8:0]      job_ymin;
  logic [8:0]      job_ymax;
  logic [ID_W-1:0] job_id;
  logic            fill_start;
  logic [8:0]      fill_row;
  logic            fill_done;
  logic            busy;
  logic            tri_done;
  logic [ID_W-1:0] tri_done_id;
  logic [9:0]      tri_done_rows;
  logic            timeout_err;

  modport slave (
    input  abort, job_valid, job_ymin, job_ymax, job_id, fill_done,
    output job_ready, fill_start, fill_row, busy, tri_done, tri_done_id,
           tri_done_rows, timeout_err
  );

  modport master (
    output abort, job_valid, job_ymin, job_ymax, job_id, fill_done,
    input  job_ready, fill_start, fill_row, busy, tri_done, tri_done_id,
           tri_done_rows, timeout_err
  );
endinterface

// File: rtl/fill_scheduler.sv
// Buffers triangle fill jobs and walks the fill unit over each triangle's
// rows one at a time, with a per-row watchdog and per-triangle completion.
module fill_scheduler #(
  parameter int DEPTH   = 4,
  parameter int ID_W    = 4,
  parameter int MAX_ROW = 479,
  parameter int TIMEOUT = 2048,
  parameter int TO_W    = 12
) (
  input logic             clk,
  input logic             n_rst,
  fill_scheduler_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  typedef struct packed {
    logic [8:0]      ymin;
    logic [8:0]      ymax;
    logic [ID_W-1:0] id;
  } job_t;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, NEXT, FINISH} state_t;

  job_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             job_ready, push, pop;
  job_t             head;
  logic [8:0]       ymax_clamp;

  state_t           state_q;
  logic [8:0]       cur_q, ymax_q;
  logic [ID_W-1:0]  id_q;
  logic [9:0]       rows_q;
  logic [TO_W-1:0]  wd_q;
  logic             fill_start_q, tri_done_q, timeout_err_q;
  logic [8:0]       fill_row_q;
  logic [ID_W-1:0]  tri_done_id_q;
  logic [9:0]       tri_done_rows_q;

  // Ready comes from the registered count only, so it never depends on pop.
  assign job_ready  = (cnt_q != CNT_W'(DEPTH));
  assign push       = bus.job_valid && job_ready && !bus.abort;
  assign pop        = (state_q == LOAD) && !bus.abort;
  assign head       = mem_q[rd_ptr_q];
  assign ymax_clamp = (head.ymax > 9'(MAX_ROW)) ? 9'(MAX_ROW) : head.ymax;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{ymin: bus.job_ymin, ymax: bus.job_ymax, id: bus.job_id};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (bus.abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Pulse outputs default low every cycle; the watchdog counts cycles since fill_start.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      cur_q           <= '0;
      ymax_q          <= '0;
      id_q            <= '0;
      rows_q          <= '0;
      wd_q            <= '0;
      fill_start_q    <= 1'b0;
      fill_row_q      <= '0;
      tri_done_q      <= 1'b0;
      tri_done_id_q   <= '0;
      tri_done_rows_q <= '0;
      timeout_err_q   <= 1'b0;
    end else begin
      fill_start_q    <= 1'b0;
      tri_done_q      <= 1'b0;
      tri_done_id_q   <= '0;
      tri_done_rows_q <= '0;
      timeout_err_q   <= 1'b0;
      if (bus.abort) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (cnt_q != '0 || push) state_q <= LOAD;
          LOAD: begin
            cur_q  <= head.ymin;
            ymax_q <= ymax_clamp;
            id_q   <= head.id;
            wd_q   <= '0;
            if (head.ymin > ymax_clamp) begin
              rows_q          <= '0;
              tri_done_q      <= 1'b1;
              tri_done_id_q   <= head.id;
              tri_done_rows_q <= '0;
              state_q         <= FINISH;
            end else begin
              rows_q       <= 10'd1;
              fill_start_q <= 1'b1;
              fill_row_q   <= head.ymin;
              state_q      <= ISSUE;
            end
          end
          ISSUE: begin
            wd_q    <= wd_q + 1'b1;
            state_q <= WAIT;
          end
          WAIT: begin
            wd_q <= wd_q + 1'b1;
            if (bus.fill_done) begin
              state_q <= NEXT;
            end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
              timeout_err_q <= 1'b1;
              state_q       <= NEXT;
            end
          end
          NEXT: begin
            if (cur_q == ymax_q) begin
              tri_done_q      <= 1'b1;
              tri_done_id_q   <= id_q;
              tri_done_rows_q <= rows_q;
              state_q         <= FINISH;
            end else begin
              cur_q        <= cur_q + 9'd1;
              fill_row_q   <= cur_q + 9'd1;
              fill_start_q <= 1'b1;
              rows_q       <= rows_q + 10'd1;
              wd_q         <= '0;
              state_q      <= ISSUE;
            end
          end
          FINISH:  state_q <= (cnt_q != '0) ? LOAD : IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.job_ready     = job_ready;
  assign bus.fill_start    = fill_start_q;
  assign bus.fill_row      = fill_row_q;
  assign bus.busy          = (state_q != IDLE) || (cnt_q != '0);
  assign bus.tri_done      = tri_done_q;
  assign bus.tri_done_id   = tri_done_id_q;
  assign bus.tri_done_rows = tri_done_rows_q;
  assign bus.timeout_err   = timeout_err_q;
endmodule

// File: tb/tb_fill_scheduler.sv
// Randomized bench for fill_scheduler: a job/row reference model plus a
// responding fill unit, with directed boundary, abort and reset scenarios.
module tb_fill_scheduler;
  localparam int DEPTH = 4, ID_W = 4, MAX_ROW = 479, TMO = 16, TO_W = 5;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  fill_scheduler_if #(.ID_W(ID_W)) ifc ();

  fill_scheduler #(.DEPTH(DEPTH), .ID_W(ID_W), .MAX_ROW(MAX_ROW), .TIMEOUT(TMO), .TO_W(TO_W)) dut (
    .clk(clk), .n_rst(n_rst), .bus(ifc)
  );

  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct { int id; int ymin; int ymax; } job_t;
  job_t jq[$];
  int   exp_rows[$];
  bit   act, in_wait, stray_done, abort_seen;
  int   act_id, act_cnt, s_cyc, d_cur, cur_row;
  int   exp_ev = -1, last_td = -10, cyc = 0;
  int   withhold_row = -1, coincide_row = -1, fixed_d = 0;
  int   n_fs = 0, n_td = 0, n_to = 0, n_stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int clampy(input int y);
    return (y > MAX_ROW) ? MAX_ROW : y;
  endfunction

  // Reference model and fill-unit responder, evaluated mid-cycle.
  always @(negedge clk) begin
    bit ev, to_handled, auto_done, idle;
    job_t j;
    ev = 0; to_handled = 0; auto_done = 0;
    if (!n_rst) begin
      jq.delete(); exp_rows.delete();
      act = 0; in_wait = 0; exp_ev = -1; abort_seen = 0;
      ifc.fill_done = 1'b0;
    end else begin
      if (abort_seen) begin
        chk("abort_busy", ifc.busy, 0);
        chk("abort_ready", ifc.job_ready, 1);
        abort_seen = 0;
      end
      if (ifc.fill_start) begin
        ev = 1; n_fs++;
        if (in_wait) chk("fs_during_wait", 1, 0);
        else begin
          if (!act) begin
            if (jq.size() == 0) chk("fs_unexpected", 1, 0);
            else begin
              j = jq.pop_front();
              act = 1; act_id = j.id; act_cnt = 0;
              exp_rows.delete();
              for (int r = j.ymin; r <= clampy(j.ymax); r++) exp_rows.push_back(r);
            end
          end
          if (act) begin
            if (exp_rows.size() == 0) chk("fs_extra_row", 1, 0);
            else begin
              cur_row = exp_rows.pop_front();
              act_cnt++;
              chk("fs_row", ifc.fill_row, cur_row);
              if (exp_ev >= 0) chk("fs_time", cyc, exp_ev);
              exp_ev = -1; in_wait = 1; s_cyc = cyc;
              if (cur_row == withhold_row) d_cur = 0;
              else if (cur_row == coincide_row) d_cur = TMO - 1;
              else if (fixed_d > 0) d_cur = fixed_d;
              else begin
                int r;
                r = $urandom_range(0, 9);
                d_cur = (r == 0) ? 0 : (r == 1) ? TMO - 1 : $urandom_range(1, 6);
              end
            end
          end
        end
      end
      if (ifc.tri_done) begin
        ev = 1; n_td++;
        if (in_wait) chk("td_during_wait", 1, 0);
        else if (act) begin
          chk("td_rows_left", exp_rows.size(), 0);
          chk("td_id", ifc.tri_done_id, act_id);
          chk("td_rows", ifc.tri_done_rows, act_cnt);
          if (exp_ev >= 0) chk("td_time", cyc, exp_ev);
          act = 0;
        end else if (jq.size() > 0) begin
          j = jq.pop_front();
          chk("td_degenerate", j.ymin > clampy(j.ymax), 1);
          chk("td_id", ifc.tri_done_id, j.id);
          chk("td_rows", ifc.tri_done_rows, 0);
          if (exp_ev >= 0) chk("td_time", cyc, exp_ev);
        end else chk("td_unexpected", 1, 0);
        last_td = cyc;
        exp_ev = (jq.size() > 0) ? cyc + 2 : -1;
      end
      if (in_wait && cyc > s_cyc) begin
        to_handled = 1;
        if (d_cur == 0 && cyc == s_cyc + TMO) begin
          chk("timeout_pulse", ifc.timeout_err, 1);
          n_to++; in_wait = 0; exp_ev = cyc + 1;
        end else begin
          chk("row_stable", ifc.fill_row, cur_row);
          chk("busy_wait", ifc.busy, 1);
          chk("ready_wait", ifc.job_ready, jq.size() < DEPTH);
          chk("timeout_early", ifc.timeout_err, 0);
          if (d_cur != 0 && cyc == s_cyc + d_cur) begin
            auto_done = 1; in_wait = 0; exp_ev = cyc + 2;
          end
        end
      end
      if (!to_handled && ifc.timeout_err) chk("timeout_unexpected", 1, 0);
      if (!ev && exp_ev >= 0 && cyc >= exp_ev) begin
        chk("event_late", cyc, exp_ev);
        exp_ev = -1;
      end
      if (ifc.job_valid && ifc.job_ready && !ifc.abort) begin
        idle = !act && !in_wait && jq.size() == 0 && cyc != last_td;
        j.id = ifc.job_id; j.ymin = ifc.job_ymin; j.ymax = ifc.job_ymax;
        jq.push_back(j);
        if (idle) exp_ev = cyc + 2;
      end
      if (ifc.abort) begin
        jq.delete(); exp_rows.delete();
        act = 0; in_wait = 0; exp_ev = -1; abort_seen = 1;
      end
      ifc.fill_done = auto_done | stray_done;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input int id, input int ymin, input int ymax);
    int k;
    ifc.job_valid = 1'b1; ifc.job_id = ID_W'(id);
    ifc.job_ymin = 9'(ymin); ifc.job_ymax = 9'(ymax);
    k = 0;
    forever begin
      @(negedge clk);
      if (ifc.job_ready) break;
      n_stall++; k++;
      if (k > 3000) begin chk("push_timeout", 0, 1); break; end
    end
    step();
    ifc.job_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (act || in_wait || jq.size() != 0 || exp_ev >= 0 || ifc.busy) begin
      step(); k++;
      if (k > 4000) begin chk("idle_timeout", 0, 1); break; end
    end
    repeat (2) step();
  endtask

  task automatic wait_fs();
    int k;
    k = 0;
    do begin
      @(negedge clk); k++;
      if (k > 2000) begin chk("fs_wait_timeout", 0, 1); break; end
    end while (!ifc.fill_start);
    step();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_fill_start"}, ifc.fill_start, 0);
    chk({tag, "_fill_row"}, ifc.fill_row, 0);
    chk({tag, "_tri_done"}, ifc.tri_done, 0);
    chk({tag, "_tri_id"}, ifc.tri_done_id, 0);
    chk({tag, "_tri_rows"}, ifc.tri_done_rows, 0);
    chk({tag, "_timeout"}, ifc.timeout_err, 0);
    chk({tag, "_busy"}, ifc.busy, 0);
    chk({tag, "_ready"}, ifc.job_ready, 1);
  endtask

  initial begin
    int td0, to0, fs0, ymin, ymax, r;
    ifc.abort = 1'b0; ifc.job_valid = 1'b0; ifc.job_id = '0;
    ifc.job_ymin = '0; ifc.job_ymax = '0; stray_done = 0;
    repeat (3) @(posedge clk);
    #2 check_reset_vals("rst");
    step(); n_rst = 1'b1;
    step();

    // Single job, fill_done four cycles after each start.
    fixed_d = 4; td0 = n_td;
    push(3, 10, 12);
    wait_idle();
    chk("single_td_count", n_td - td0, 1);

    // Long first job so the FIFO fills, then one more must stall.
    fixed_d = 6; td0 = n_td; n_stall = 0;
    push(1, 100, 111);
    for (int i = 0; i < 5; i++) push(4 + i, 20 + i, 21 + i);
    wait_idle();
    chk("full_stall_seen", n_stall > 0, 1);
    chk("full_td_count", n_td - td0, 6);

    // Row clamp at the bottom of the screen and an inverted extent.
    fixed_d = 2; td0 = n_td;
    push(5, 470, 500);
    push(6, 20, 5);
    wait_idle();
    chk("bound_td_count", n_td - td0, 2);

    // Watchdog expiry on row 7; fill_done exactly on the expiry cycle for row 8.
    fixed_d = 3; withhold_row = 7; coincide_row = 8; to0 = n_to;
    push(7, 6, 9);
    wait_idle();
    chk("timeout_count", n_to - to0, 1);
    withhold_row = -1; coincide_row = -1;

    // Random traffic.
    fixed_d = 0;
    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 7);
      if (r == 0) begin ymin = $urandom_range(50, 400); ymax = ymin - $urandom_range(1, 40); end
      else if (r == 1) begin ymin = $urandom_range(470, 479); ymax = $urandom_range(ymin, 511); end
      else if (r == 2) begin ymin = $urandom_range(480, 511); ymax = $urandom_range(0, 511); end
      else begin ymin = $urandom_range(0, 470); ymax = ymin + $urandom_range(0, 4); end
      push($urandom_range(0, 15), ymin, ymax);
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle();

    // Abort while waiting on a row with two jobs queued and a job offered.
    fixed_d = 12;
    push(9, 200, 205);
    wait_fs();
    push(10, 30, 31);
    push(11, 40, 41);
    td0 = n_td;
    ifc.abort = 1'b1; ifc.job_valid = 1'b1; ifc.job_id = 4'd12;
    ifc.job_ymin = 9'd1; ifc.job_ymax = 9'd2;
    step();
    ifc.abort = 1'b0; ifc.job_valid = 1'b0;
    fs0 = n_fs;
    step(); stray_done = 1; step(); stray_done = 0;
    repeat (20) step();
    chk("abort_no_fs", n_fs - fs0, 0);
    chk("abort_no_td", n_td - td0, 0);
    chk("abort_idle_busy", ifc.busy, 0);

    // Asynchronous reset in the middle of a row wait.
    fixed_d = 10;
    push(13, 300, 303);
    wait_fs();
    step();
    #1 n_rst = 1'b0;
    #1 check_reset_vals("async");
    step();
    n_rst = 1'b1;
    step();
    fixed_d = 3; td0 = n_td;
    push(14, 40, 42);
    wait_idle();
    chk("post_reset_td_count", n_td - td0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: got stuck, expected finish");
    $fatal(1);
  end
endmodule
